// File: rtl/tile_update_master.sv
// Avalon-MM write master that drains a FIFO of {x, y, type} tile updates into
// the tile peripheral as three ordered register writes, optionally gated to vblank.
module tile_update_master #(
    parameter int DEPTH       = 16,
    parameter bit GATE_VBLANK = 1'b1,
    parameter int BASE_ADDR   = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [7:0]               s_x,
    input  logic [7:0]               s_y,
    input  logic [7:0]               s_type,
    input  logic                     vblank,
    output logic                     m_chipselect,
    output logic                     m_write,
    output logic [2:0]               m_address,
    output logic [7:0]               m_writedata,
    input  logic                     m_waitrequest,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] ADDR_X = 3'(BASE_ADDR);
    localparam logic [2:0] ADDR_Y = ADDR_X + 3'd1;
    localparam logic [2:0] ADDR_T = ADDR_X + 3'd2;

    typedef enum logic [1:0] {IDLE, WR_X, WR_Y, WR_T} state_t;

    logic [23:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    state_t        state_q, state_d;
    logic [2:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    y_q, y_d;
    logic [7:0]    t_q, t_d;
    logic          push, pop, start, launch;
    logic [23:0]   head;

    assign s_ready = (level_q != (AW+1)'(DEPTH));
    assign push    = s_valid && s_ready;
    assign head    = mem_q[rd_ptr_q];
    // vblank only matters at the moment a new triple is launched.
    assign start   = (level_q != '0) && (!GATE_VBLANK || vblank);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        y_d     = y_q;
        t_d     = t_q;
        launch  = 1'b0;
        case (state_q)
            IDLE: launch = start;
            WR_X: if (!m_waitrequest) begin
                state_d = WR_Y;
                addr_d  = ADDR_Y;
                data_d  = y_q;
            end
            WR_Y: if (!m_waitrequest) begin
                state_d = WR_T;
                addr_d  = ADDR_T;
                data_d  = t_q;
            end
            WR_T: if (!m_waitrequest) begin
                if (start) begin
                    launch = 1'b1;
                end else begin
                    state_d = IDLE;
                    addr_d  = '0;
                    data_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Popping straight from WR_T keeps back-to-back updates at 3 cycles each.
        if (launch) begin
            state_d = WR_X;
            addr_d  = ADDR_X;
            data_d  = head[23:16];
            y_d     = head[15:8];
            t_d     = head[7:0];
        end
        pop = launch;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_x, s_y, s_type};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            y_q      <= '0;
            t_q      <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            y_q      <= y_d;
            t_q      <= t_d;
        end
    end

    assign m_write      = (state_q != IDLE);
    assign m_chipselect = m_write;
    assign m_address    = addr_q;
    assign m_writedata  = data_q;
    assign level        = level_q;
    assign busy         = (state_q != IDLE) || (level_q != '0);

endmodule

// File: tb/tb_tile_update_master.sv
// Directed bench for tile_update_master: expected Avalon beats are queued as
// updates are accepted and a negedge monitor pops and compares every completed beat.
module tb_tile_update_master;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_x, s_y, s_type;
    logic       vblank;
    logic       m_chipselect, m_write;
    logic [2:0] m_address;
    logic [7:0] m_writedata;
    logic       m_waitrequest;
    logic [2:0] level;
    logic       busy;

    int          checks = 0;
    int          errors = 0;
    logic [10:0] exp_q[$];
    logic [10:0] mon_e;
    int          run_len = 0;
    int          max_run = 0;
    logic        stall_prev = 1'b0;
    logic [2:0]  prev_addr = '0;
    logic [7:0]  prev_data = '0;

    tile_update_master #(
        .DEPTH(4),
        .GATE_VBLANK(1'b1),
        .BASE_ADDR(0)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_x(s_x),
        .s_y(s_y),
        .s_type(s_type),
        .vblank(vblank),
        .m_chipselect(m_chipselect),
        .m_write(m_write),
        .m_address(m_address),
        .m_writedata(m_writedata),
        .m_waitrequest(m_waitrequest),
        .level(level),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one update for a single cycle; an accepted update queues its three beats.
    task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic [7:0] t, output bit acc);
        s_x     = x;
        s_y     = y;
        s_type  = t;
        s_valid = 1'b1;
        @(negedge clk);
        acc = s_ready;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        if (acc) begin
            exp_q.push_back({3'd0, x});
            exp_q.push_back({3'd1, y});
            exp_q.push_back({3'd2, t});
        end
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(n >= 300), 0);
        tick();
    endtask

    // Monitor: handshake rules on every cycle, scoreboard compare on every completed beat.
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
            run_len    = 0;
        end else begin
            checkOutput("cs_eq_write", m_chipselect, m_write);
            if (stall_prev) begin
                checkOutput("stall_write_held", m_write, 1);
                checkOutput("stall_addr_stable", m_address, prev_addr);
                checkOutput("stall_data_stable", m_writedata, prev_data);
            end
            if (m_write && !m_waitrequest) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", m_address, m_writedata);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("beat_addr", m_address, mon_e[10:8]);
                    checkOutput("beat_data", m_writedata, mon_e[7:0]);
                end
            end
            stall_prev = m_write && m_waitrequest;
            prev_addr  = m_address;
            prev_data  = m_writedata;
            run_len    = m_write ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;
        int acc_cnt;
        int cnt;
        logic seen;

        reset_n       = 1'b0;
        s_valid       = 1'b0;
        s_x           = '0;
        s_y           = '0;
        s_type        = '0;
        vblank        = 1'b0;
        m_waitrequest = 1'b0;
        repeat (3) tick();
        checkOutput("rst_m_write", m_write, 0);
        checkOutput("rst_m_cs", m_chipselect, 0);
        checkOutput("rst_m_addr", m_address, 0);
        checkOutput("rst_m_data", m_writedata, 0);
        checkOutput("rst_s_ready", s_ready, 1);
        checkOutput("rst_level", level, 0);
        checkOutput("rst_busy", busy, 0);
        reset_n = 1'b1;
        repeat (3) tick();

        // Single update latency: x, y, type on the 2nd..4th cycle after acceptance.
        vblank = 1'b1;
        applyStimulus(8'h05, 8'h07, 8'h01, acc);
        checkOutput("t1_accept", acc, 1);
        @(negedge clk);
        checkOutput("t1_n1_write", m_write, 0);
        checkOutput("t1_n1_level", level, 1);
        checkOutput("t1_n1_busy", busy, 1);
        @(negedge clk);
        checkOutput("t1_x_write", m_write, 1);
        checkOutput("t1_x_addr", m_address, 0);
        checkOutput("t1_x_data", m_writedata, 8'h05);
        @(negedge clk);
        checkOutput("t1_y_addr", m_address, 1);
        checkOutput("t1_y_data", m_writedata, 8'h07);
        @(negedge clk);
        checkOutput("t1_t_addr", m_address, 2);
        checkOutput("t1_t_data", m_writedata, 8'h01);
        @(negedge clk);
        checkOutput("t1_done_write", m_write, 0);
        checkOutput("t1_done_busy", busy, 0);
        checkOutput("t1_done_level", level, 0);
        tick();

        // Four wait cycles on the y beat.
        applyStimulus(8'h11, 8'h22, 8'h33, acc);
        tick();
        tick();
        m_waitrequest = 1'b1;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (m_write && m_address == 3'd1 && m_writedata == 8'h22) cnt++;
            tick();
        end
        m_waitrequest = 1'b0;
        @(negedge clk);
        if (m_write && m_address == 3'd1 && m_writedata == 8'h22) cnt++;
        checkOutput("t2_y_hold_cycles", cnt, 5);
        @(negedge clk);
        checkOutput("t2_t_write", m_write, 1);
        checkOutput("t2_t_addr", m_address, 2);
        checkOutput("t2_t_data", m_writedata, 8'h33);
        waitIdle("t2_idle_timeout");

        // Fill the 4-deep FIFO while gated off and stalled.
        vblank        = 1'b0;
        m_waitrequest = 1'b1;
        acc_cnt       = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i), acc);
            acc_cnt += int'(acc);
        end
        @(negedge clk);
        checkOutput("t3_accepted", acc_cnt, 4);
        checkOutput("t3_level_full", level, 4);
        checkOutput("t3_s_ready_full", s_ready, 0);
        checkOutput("t3_no_write", m_write, 0);
        tick();
        vblank        = 1'b1;
        m_waitrequest = 1'b0;
        applyStimulus(8'hEE, 8'hEE, 8'hEE, acc);
        checkOutput("t3_full_pop_no_accept", acc, 0);
        waitIdle("t3_idle_timeout");
        checkOutput("t3_level_drained", level, 0);

        // vblank gating: a triple finishes once started, the next waits for blank.
        vblank = 1'b0;
        applyStimulus(8'h41, 8'h42, 8'h43, acc);
        applyStimulus(8'h51, 8'h52, 8'h53, acc);
        repeat (5) begin
            @(negedge clk);
            checkOutput("t4_no_write_low", m_write, 0);
            tick();
        end
        checkOutput("t4_level_two", level, 2);
        vblank = 1'b1;
        tick();
        tick();
        vblank = 1'b0;
        @(negedge clk);
        checkOutput("t4_mid_write", m_write, 1);
        checkOutput("t4_mid_addr", m_address, 1);
        tick();
        tick();
        @(negedge clk);
        checkOutput("t4_after_first_write", m_write, 0);
        checkOutput("t4_after_first_level", level, 1);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= m_write;
        end
        checkOutput("t4_second_gated", seen, 0);
        tick();
        vblank = 1'b1;
        waitIdle("t4_idle_timeout");

        // Back-to-back updates must stream with no idle bubble.
        max_run = 0;
        applyStimulus(8'h61, 8'h62, 8'h63, acc);
        applyStimulus(8'h71, 8'h72, 8'h73, acc);
        applyStimulus(8'h81, 8'h82, 8'h83, acc);
        waitIdle("t5_idle_timeout");
        checkOutput("t5_consecutive_writes", max_run, 9);

        // Asynchronous reset during the y beat.
        applyStimulus(8'h91, 8'h92, 8'h93, acc);
        applyStimulus(8'hA1, 8'hA2, 8'hA3, acc);
        applyStimulus(8'hB1, 8'hB2, 8'hB3, acc);
        checkOutput("t6_pre_level", level, 2);
        checkOutput("t6_pre_write", m_write, 1);
        checkOutput("t6_pre_addr", m_address, 1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_write", m_write, 0);
        checkOutput("t6_rst_cs", m_chipselect, 0);
        checkOutput("t6_rst_addr", m_address, 0);
        checkOutput("t6_rst_data", m_writedata, 0);
        checkOutput("t6_rst_level", level, 0);
        checkOutput("t6_rst_busy", busy, 0);
        checkOutput("t6_rst_s_ready", s_ready, 1);
        exp_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= m_write;
        end
        checkOutput("t6_no_write_after", seen, 0);
        checkOutput("t6_level_after", level, 0);

        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
